// File: rtl/sound_pkg.sv
// Shared encodings for the Pong sound event sequencer: FSM states and the
// Cause select values understood by the sound player.
package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GUARD  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam logic CAUSE_HIT   = 1'b0;
    localparam logic CAUSE_POINT = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sound_event_sequencer_hold_timer.sv
// Loadable down-counter with a zero flag; times the HOLD, LOCKOUT and GAP
// intervals of the sound event sequencer. Stops at zero, never wraps.
module hold_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sound_event_sequencer.sv
// Turns single-cycle Pong event pulses into a stretched PlayAgain level and a
// stable Cause select. Optional point preemption is enabled by SOUND_PREEMPT_EN.
module sound_event_sequencer
    import sound_pkg::*;
#(
    parameter int HOLD_CYCLES    = 2_000_000,
    parameter int LOCKOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hit_paddle,
    input  logic hit_wall,
    input  logic point_scored,
    output logic play_again,
    output logic cause,
    output logic busy,
    output logic coalesced
);

    localparam int CW_RAW = $clog2(max2(HOLD_CYCLES, LOCKOUT_CYCLES));
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT_CYCLES - 1);

    state_t          state;
    logic            pend_hit;
    logic            pend_point;
    logic            hit_req;
    logic            point_req;
    logic            in_service;
    logic            start;
    logic            preempt;
    logic            hold_done;
    logic            timer_load;
    logic [CW-1:0]   timer_value;
    logic            timer_zero;

    assign hit_req    = hit_paddle | hit_wall;
    assign point_req  = point_scored;
    assign in_service = (state == ST_ASSERT) || (state == ST_GUARD);
    assign start      = (state == ST_IDLE) && (pend_hit || pend_point || hit_req || point_req);

`ifdef SOUND_PREEMPT_EN
    // A point outranks a hit score even mid-playback; the GAP that follows
    // gives the player's debouncer a clean low before the point trigger.
    assign preempt = in_service && point_req && (cause == CAUSE_HIT);
`else
    assign preempt = 1'b0;
`endif

    assign hold_done   = (state == ST_ASSERT) && timer_zero && !preempt;
    assign timer_load  = start || preempt || hold_done;
    assign timer_value = hold_done ? LOCK_LOAD : HOLD_LOAD;

    hold_timer #(.WIDTH(CW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .value (timer_value),
        .zero  (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pend_hit   <= 1'b0;
            pend_point <= 1'b0;
            play_again <= 1'b0;
            cause      <= CAUSE_HIT;
            busy       <= 1'b0;
            coalesced  <= 1'b0;
        end else begin
            coalesced  <= (hit_req   && (pend_hit   || (in_service && cause == CAUSE_HIT)))
                       || (point_req && (pend_point || (in_service && cause == CAUSE_POINT)));
            pend_hit   <= pend_hit   | hit_req;
            pend_point <= pend_point | point_req;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_ASSERT;
                        play_again <= 1'b1;
                        busy       <= 1'b1;
                        // The served flag is cleared; the other keeps any new request.
                        if (pend_point || point_req) begin
                            cause      <= CAUSE_POINT;
                            pend_point <= 1'b0;
                        end else begin
                            cause    <= CAUSE_HIT;
                            pend_hit <= 1'b0;
                        end
                    end
                end
                ST_ASSERT: begin
                    if (preempt) begin
                        state      <= ST_GAP;
                        play_again <= 1'b0;
                    end else if (timer_zero) begin
                        state      <= ST_GUARD;
                        play_again <= 1'b0;
                    end
                end
                ST_GUARD: begin
                    if (preempt) begin
                        state <= ST_GAP;
                    end else if (timer_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef SOUND_PREEMPT_EN
                ST_GAP: begin
                    if (timer_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    play_again <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
